// File: rtl/dot_product_feeder.sv
// dot_product_feeder
// Initiator-side sequencer for a dot-product core's load/start/done interface.
// Accepts a length command plus an interleaved operand stream (A0,B0,A1,B1,...).
// Writes each word into the core's A/B memories and pulses start_calc. It then
// waits for calc_done and returns the result (or an error) on a valid/ready port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. Ready is never a function of valid on the same port. Once the
// feeder raises res_valid, it holds res_valid, res_data and res_error stable
// until res_ready is seen.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_len command channel (vector length)
//   s_data/s_valid/s_ready     operand word stream
//   data_in, write_addr,
//   write_en_a, write_en_b     memory write port toward the core
//   start_calc, vector_length  calculation kick-off toward the core
//   calc_done, result          completion and dot product from the core
//   res_data/res_error/
//   res_valid/res_ready        result channel
//   busy                       high in every state except IDLE
//   state_dbg                  current FSM state, for observation
module dot_product_feeder #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_VECTOR_SIZE = 7,
  parameter int ADDR_WIDTH      = 3,
  parameter int LEN_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  write_en_a,
  output logic                  write_en_b,
  output logic                  start_calc,
  output logic [LEN_WIDTH-1:0]  vector_length,
  input  logic                  calc_done,
  input  logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_error,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]        TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_VECTOR_SIZE);
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] idx;
  logic [TW-1:0]        tmo_cnt;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      len           <= '0;
      idx           <= '0;
      tmo_cnt       <= '0;
      cmd_ready     <= 1'b0;
      s_ready       <= 1'b0;
      data_in       <= '0;
      write_addr    <= '0;
      write_en_a    <= 1'b0;
      write_en_b    <= 1'b0;
      start_calc    <= 1'b0;
      vector_length <= '0;
      res_data      <= '0;
      res_error     <= 1'b0;
      res_valid     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      // Strobes and the start pulse are one cycle wide unless re-armed below.
      write_en_a <= 1'b0;
      write_en_b <= 1'b0;
      start_calc <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0 || cmd_len > MAX_LEN) begin
              res_data  <= '0;
              res_error <= 1'b1;
              res_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              len     <= cmd_len;
              idx     <= '0;
              s_ready <= 1'b1;
              state   <= S_LOAD_A;
            end
          end else begin
            // Comes up one edge after reset release.
            cmd_ready <= 1'b1;
          end
        end

        S_LOAD_A: begin
          if (s_valid && s_ready) begin
            data_in    <= s_data;
            write_addr <= idx[ADDR_WIDTH-1:0];
            write_en_a <= 1'b1;
            state      <= S_LOAD_B;
          end
        end

        S_LOAD_B: begin
          if (s_valid && s_ready) begin
            data_in    <= s_data;
            write_addr <= idx[ADDR_WIDTH-1:0];
            write_en_b <= 1'b1;
            idx        <= idx + ONE;
            if (idx == len - ONE) begin
              s_ready <= 1'b0;
              state   <= S_START;
            end else begin
              state <= S_LOAD_A;
            end
          end
        end

        S_START: begin
          start_calc    <= 1'b1;
          vector_length <= len;
          tmo_cnt       <= '0;
          state         <= S_WAIT;
        end

        S_WAIT: begin
          // The first WAIT cycle is the start_calc cycle. calc_done there may
          // still reflect the previous calculation, so it is skipped.
          if (!start_calc) begin
            if (calc_done) begin
              res_data  <= result;
              res_error <= 1'b0;
              res_valid <= 1'b1;
              state     <= S_RESP;
            end else if (tmo_cnt == TO_LAST) begin
              res_data  <= '0;
              res_error <= 1'b1;
              res_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end

        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b0;
          s_ready   <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_feeder.sv
// Self-checking bench for dot_product_feeder.
// It contains a stub core that returns a programmed result, a strobe
// scoreboard, table-driven transactions, and hand-written corner-case
// sequences.
module tb_dot_product_feeder;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int LW = 4;
  localparam int TO = 16;
  localparam int SW = 1 + AW + DW;  // scoreboard entry: {is_b, addr, data}

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] data_in;
  logic [AW-1:0] write_addr;
  logic          write_en_a;
  logic          write_en_b;
  logic          start_calc;
  logic [LW-1:0] vector_length;
  logic          calc_done;
  logic [DW-1:0] result;
  logic [DW-1:0] res_data;
  logic          res_error;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic [2:0]    state_dbg;

  dot_product_feeder #(
    .DATA_WIDTH(DW), .MAX_VECTOR_SIZE(7), .ADDR_WIDTH(AW),
    .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .data_in(data_in), .write_addr(write_addr),
    .write_en_a(write_en_a), .write_en_b(write_en_b),
    .start_calc(start_calc), .vector_length(vector_length),
    .calc_done(calc_done), .result(result),
    .res_data(res_data), .res_error(res_error),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int exp_starts = 0;
  logic [LW-1:0] exp_vlen = '0;
  logic prev_start = 1'b0;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (write_en_a || write_en_b) begin
        check("strobe_exclusive", 64'(write_en_a & write_en_b), 64'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL strobe_unexpected: got b=%0b addr=%0d data=%h, expected no strobe",
                   write_en_b, write_addr, data_in);
        end else begin
          check("strobe_seq", 64'({write_en_b, write_addr, data_in}), 64'(exp_q.pop_front()));
        end
      end
      if (start_calc) begin
        check("start_single_cycle", 64'(prev_start), 64'd0);
        check("vector_length", 64'(vector_length), 64'(exp_vlen));
        start_cnt++;
      end
      prev_start = start_calc;
    end else begin
      prev_start = 1'b0;
    end
  end

  // ---------------- core stub ----------------
  logic          core_respond = 1'b1;
  logic          core_early   = 1'b0;
  logic [DW-1:0] core_res     = '0;

  initial begin
    calc_done = 1'b0;
    result    = '0;
    forever begin
      @(negedge clk);
      if (rstn && start_calc) begin
        if (core_early) begin
          // Stale done with a bogus result during the start_calc cycle only.
          calc_done = 1'b1;
          result    = 32'hDEADBEEF;
          @(negedge clk);
          calc_done = 1'b0;
        end
        if (core_respond) begin
          repeat (2) @(negedge clk);
          result    = core_res;
          calc_done = 1'b1;
          for (int n = 0; n < 64 && !res_valid; n++) @(negedge clk);
          calc_done = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_cmd(input logic [LW-1:0] len);
    int n;
    cmd_len   = len;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_ready_wait_bound", 64'(n < 100), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap);
    int n;
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    check("s_ready_wait_bound", 64'(n < 100), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic get_resp(input logic exp_err, input logic [DW-1:0] exp_data, input int delay);
    int n;
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    check("res_valid_wait_bound", 64'(n < 200), 64'd1);
    check("res_fields", 64'({res_error, res_data}), 64'({exp_err, exp_data}));
    for (int d = 0; d < delay; d++) begin
      check("backpressure_hold",
            64'({res_valid, res_error, res_data, cmd_ready, busy}),
            64'({1'b1, exp_err, exp_data, 1'b0, 1'b1}));
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("after_accept", 64'({res_valid, cmd_ready, busy}), 64'({1'b0, 1'b1, 1'b0}));
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [LW-1:0]        len;
    logic [13:0][DW-1:0]  words;
    logic [DW-1:0]        core_res;
    logic                 early;
    logic                 exp_err;
    logic [DW-1:0]        exp_data;
  } vec_t;

  task automatic push_expect(input vec_t v, input int upto);
    for (int i = 0; i < upto; i++) begin
      if (i % 2 == 0) exp_q.push_back({1'b0, AW'(i / 2), v.words[i]});
      else            exp_q.push_back({1'b1, AW'(i / 2), v.words[i]});
    end
  endtask

  task automatic run_txn(input vec_t v, input int gap, input int delay);
    logic ok_len;
    ok_len       = (v.len != '0) && (v.len <= LW'(7));
    core_res     = v.core_res;
    core_early   = v.early;
    core_respond = 1'b1;
    exp_vlen     = v.len;
    if (ok_len) begin
      push_expect(v, 2 * int'(v.len));
      exp_starts++;
    end
    send_cmd(v.len);
    if (ok_len) for (int i = 0; i < 2 * int'(v.len); i++) send_word(v.words[i], gap);
    get_resp(v.exp_err, v.exp_data, delay);
    check("strobes_drained", 64'(exp_q.size()), 64'd0);
    check("start_count", 64'(start_cnt), 64'(exp_starts));
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[6];
  vec_t v;
  int   n;

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
    s_data = '0; s_valid = 1'b0; res_ready = 1'b0;

    // Length 2, back-to-back: A=[1,2] B=[3,4] -> 11.0
    vecs[0] = '0;
    vecs[0].len = 4'd2;
    vecs[0].words[0] = 32'h3F800000; vecs[0].words[1] = 32'h40400000;
    vecs[0].words[2] = 32'h40000000; vecs[0].words[3] = 32'h40800000;
    vecs[0].core_res = 32'h41300000; vecs[0].exp_data = 32'h41300000;
    // Illegal lengths: 0, 8, 15
    vecs[1] = '0; vecs[1].len = 4'd0; vecs[1].exp_err = 1'b1;
    vecs[2] = '0; vecs[2].len = 4'd8; vecs[2].exp_err = 1'b1;
    vecs[3] = '0; vecs[3].len = 4'd15; vecs[3].exp_err = 1'b1;
    // Length 1 with a stale calc_done in the start_calc cycle
    vecs[4] = '0;
    vecs[4].len = 4'd1;
    vecs[4].words[0] = 32'h3F800000; vecs[4].words[1] = 32'h40000000;
    vecs[4].core_res = 32'h40000000; vecs[4].early = 1'b1;
    vecs[4].exp_data = 32'h40000000;
    // Maximum length 7
    vecs[5] = '0;
    vecs[5].len = 4'd7;
    for (int i = 0; i < 14; i++) vecs[5].words[i] = 32'h40000000 + DW'(i * 32'h11);
    vecs[5].core_res = 32'h42C80000; vecs[5].exp_data = 32'h42C80000;

    // Reset state
    #2;
    check("reset_outputs",
          64'({cmd_ready, s_ready, write_en_a, write_en_b, start_calc, res_valid,
               res_error, busy, state_dbg, vector_length}), 64'd0);
    check("reset_data", 64'({data_in, res_data}), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("cmd_ready_after_edge", 64'({cmd_ready, busy}), 64'({1'b1, 1'b0}));

    for (int k = 0; k < 6; k++) run_txn(vecs[k], 0, 0);

    // Length 3 with 2-cycle bubbles between words
    v = '0;
    v.len = 4'd3;
    v.words[0] = 32'h40000000; v.words[1] = 32'h40A00000;
    v.words[2] = 32'hC0800000; v.words[3] = 32'h3F800000;
    v.words[4] = 32'h40400000; v.words[5] = 32'h40000000;
    v.core_res = 32'h41400000; v.exp_data = 32'h41400000;
    run_txn(v, 2, 0);

    // Result back-pressure: res_ready low 5 cycles, accepted on the 6th
    run_txn(vecs[0], 0, 5);

    // Timeout: core never answers. res_valid must stay low for exactly TO
    // cycles after the start_calc cycle.
    v = vecs[4];
    v.early = 1'b0;
    core_respond = 1'b0;
    core_early   = 1'b0;
    exp_vlen     = v.len;
    push_expect(v, 2);
    exp_starts++;
    send_cmd(v.len);
    send_word(v.words[0], 0);
    send_word(v.words[1], 0);
    n = 0;
    while (!start_calc && n < 20) begin @(negedge clk); n++; end
    check("timeout_start_seen", 64'(start_calc), 64'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 100);
    check("timeout_low_cycles", 64'(n - 1), 64'(TO));
    get_resp(1'b1, 32'h0, 0);
    check("timeout_start_count", 64'(start_cnt), 64'(exp_starts));
    core_respond = 1'b1;

    // Reset mid-load: stop in LOAD_B with idx=1 (A0, B0, A1 written)
    v = '0;
    v.len = 4'd3;
    v.words[0] = 32'h11111111; v.words[1] = 32'h22222222; v.words[2] = 32'h33333333;
    exp_vlen = v.len;
    push_expect(v, 3);
    send_cmd(v.len);
    for (int i = 0; i < 3; i++) send_word(v.words[i], 0);
    @(negedge clk);
    check("midload_state_before_reset", 64'(state_dbg), 64'd2);
    check("midload_strobes_seen", 64'(exp_q.size()), 64'd0);
    rstn = 1'b0;
    #1;
    check("midreset_outputs",
          64'({cmd_ready, s_ready, write_en_a, write_en_b, start_calc, res_valid,
               res_error, busy, state_dbg, vector_length, write_addr}), 64'd0);
    check("midreset_data", 64'({data_in, res_data}), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_midreset", 64'({cmd_ready, busy}), 64'({1'b1, 1'b0}));

    v = '0;
    v.len = 4'd1;
    v.words[0] = 32'h3F800000; v.words[1] = 32'h3F800000;
    v.core_res = 32'h3F800000; v.exp_data = 32'h3F800000;
    run_txn(v, 0, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dot_product_feeder.md
Name: dot_product_feeder

Overview:
Initiator-side sequencer for dot_product_top's load/start/done interface. It accepts a length command and an interleaved stream of float32 operand words (A0,B0,A1,B1,...). It writes each word into the core's A/B vector memories, pulses start_calc, then waits for calc_done. It returns the captured result, or an error, on a valid/ready result port. It sits between the GRU control path and each dot-product engine, so upstream logic never drives raw write strobes.

Parameters:
DATA_WIDTH, 32, operand/result word width (IEEE-754 single).
MAX_VECTOR_SIZE, 7, largest legal vector length.
ADDR_WIDTH, 3, width of write_addr; must satisfy 2**ADDR_WIDTH >= MAX_VECTOR_SIZE.
LEN_WIDTH, 4, width of cmd_len/vector_length.
TIMEOUT_CYCLES, 1024, WAIT-state cycles allowed before declaring a timeout.

Ports:
clk  in  1  system clock, rising-edge
rstn  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  feeder can accept a command
cmd_len  in  LEN_WIDTH  vector length for this command
s_data  in  DATA_WIDTH  operand word, order A0,B0,A1,B1,...
s_valid  in  1  s_data valid
s_ready  out  1  feeder accepts s_data
data_in  out  DATA_WIDTH  to core: write data
write_addr  out  ADDR_WIDTH  to core: element index
write_en_a  out  1  to core: write A[write_addr]
write_en_b  out  1  to core: write B[write_addr]
start_calc  out  1  to core: start pulse
vector_length  out  LEN_WIDTH  to core: length, held stable from start_calc through capture
calc_done  in  1  from core: calculation complete (level)
result  in  DATA_WIDTH  from core: dot product
res_data  out  DATA_WIDTH  returned result
res_error  out  1  1 = bad length or timeout
res_valid  out  1  result/error present
res_ready  in  1  consumer accepts result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rstn low, takes effect immediately): FSM goes to IDLE. idx and the timeout counter clear. Every output is 0, including cmd_ready.
- Registered outputs: cmd_ready is registered and is 1 from the first clk edge after rstn releases.
- States and transitions:
  - IDLE: cmd_ready=1.
    - On cmd_valid & cmd_ready with cmd_len==0 or cmd_len>MAX_VECTOR_SIZE, go to RESP with res_error=1 and res_data=0. No strobes and no start_calc are issued.
    - On any other accepted command, latch len and set idx=0, then go to LOAD_A.
  - LOAD_A: s_ready=1. A handshake (s_valid & s_ready) in cycle N gives data_in=s_data, write_addr=idx and write_en_a=1 in cycle N+1 only, then the FSM goes to LOAD_B. If s_valid=0, the state holds and no strobe is issued.
  - LOAD_B: same as LOAD_A but drives write_en_b. After the handshake, idx increments.
    - If idx was len-1, go to START.
    - Otherwise return to LOAD_A.
  - START: if the last write_en_b pulse is in cycle T, start_calc=1 in cycle T+1 only. vector_length=len from T+1.
  - WAIT: calc_done is ignored in the start_calc cycle and sampled from the next cycle onward.
    - calc_done=1: capture result into res_data, set res_error=0, go to RESP.
    - After TIMEOUT_CYCLES sampled cycles without calc_done: res_data=0, res_error=1, go to RESP.
  - RESP: res_valid=1. res_data and res_error hold stable until res_ready=1. On that cycle res_valid drops on the next edge and the FSM returns to IDLE.
- Handshake gating:
  - s_ready=0 outside LOAD_A/LOAD_B; s_data is ignored there.
  - cmd_ready=0 outside IDLE; a new command cannot be accepted in the same cycle as the res_ready handshake.
- Strobe rules:
  - write_en_a and write_en_b are never both high.
  - Each strobe is at most one cycle wide per accepted word.
  - data_in and write_addr are don't-care when neither strobe is high; implementation holds their last value.
- Inputs outside their states: calc_done and result are ignored outside WAIT.
- Reset mid-operation: any in-flight transaction is abandoned and no result is emitted. The upstream side must resend both command and data.

Test Plan:
- Length-2 directed case:
  - Stimulus: cmd_len=2; s_data 3F800000, 40400000, 40000000, 40800000 back-to-back; core model returns 41300000.
  - Required: strobe sequence (addr,en) = (0,A), (0,B), (1,A), (1,B); start_calc high 1 cycle with vector_length=2; res_data=41300000, res_error=0.
- Length-3 case with bubbles:
  - Stimulus: cmd_len=3; words 40000000, 40A00000, C0800000, 3F800000, 40400000, 40000000 with s_valid low for 2 cycles between each word; core returns 41400000.
  - Required: no strobes during bubbles; res_data=41400000.
- Bad length: cmd_len=0, then cmd_len=8 -> each gives res_valid with res_error=1 and res_data=0; zero write strobes and zero start_calc.
- Timeout: TIMEOUT_CYCLES=16, core never asserts calc_done -> res_error=1 exactly 16 cycles after the start_calc cycle; res_data=0.
- Result back-pressure: res_ready held low 5 cycles -> res_valid, res_data and res_error stable; cmd_ready=0 and busy=1 throughout; accept on cycle 6, then cmd_ready=1 on the next cycle.
- Reset mid-load: rstn pulsed low in LOAD_B at idx=1 -> all outputs 0 immediately; after release, cmd_len=1 with words 3F800000, 3F800000 (core returns 3F800000) completes with res_data=3F800000.
